// File: rtl/load_store_unit_if.sv
// Bundle of exec-side request/response signals and the data-memory port of the
// load/store unit.
//   slave  : the LSU view (takes requests and mem responses, drives stall,
//            resp_*, fault_* and mem_*)
//   master : the environment view (exec stage plus memory), the mirror image
interface load_store_unit_if;
    // exec -> LSU request
    logic        req_valid;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // LSU -> exec/writeback
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault_access;
    logic        fault_timeout;
    // LSU <-> data memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  req_valid, req_load, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_ready,
        output stall, resp_valid, resp_rdata, fault_access, fault_timeout,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_load, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_ready,
        input  stall, resp_valid, resp_rdata, fault_access, fault_timeout,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one memory access from exec, checks funct3
// and alignment, drives a word-addressed memory port with byte strobes, and
// returns sign/zero-extended load data. Stalls the core while busy.
// Ports:
//   clk, reset : core clock, synchronous active-high reset
//   bus        : load_store_unit_if.slave (request, response, faults, mem port)
// Parameter:
//   TIMEOUT    : cycles mem_req is held without mem_ready before abort (1..255)
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, FAULT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic             load_q, load_d;
    logic [1:0]       addr_lo_q, addr_lo_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        fault_access_q, fault_access_d;
    logic        fault_timeout_q, fault_timeout_d;

    logic        f3_ok;
    logic        aligned;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Request decode: funct3 legality, alignment, store lane placement.
    always_comb begin
        f3_ok    = 1'b0;
        aligned  = 1'b0;
        st_strb  = 4'b0000;
        st_wdata = 32'h0;
        case (bus.req_funct3)
            3'b000: begin
                f3_ok    = 1'b1;
                aligned  = 1'b1;
                st_strb  = 4'b0001 << bus.req_addr[1:0];
                st_wdata = {4{bus.req_wdata[7:0]}};
            end
            3'b001: begin
                f3_ok    = 1'b1;
                aligned  = ~bus.req_addr[0];
                st_strb  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.req_wdata[15:0]}};
            end
            3'b010: begin
                f3_ok    = 1'b1;
                aligned  = (bus.req_addr[1:0] == 2'b00);
                st_strb  = 4'b1111;
                st_wdata = bus.req_wdata;
            end
            3'b100: begin
                f3_ok   = bus.req_load;
                aligned = 1'b1;
            end
            3'b101: begin
                f3_ok   = bus.req_load;
                aligned = ~bus.req_addr[0];
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension from the latched funct3/offset.
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        f3_d            = f3_q;
        load_d          = load_q;
        addr_lo_d       = addr_lo_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wstrb_d     = mem_wstrb_q;
        mem_wdata_d     = mem_wdata_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        fault_access_d  = 1'b0;
        fault_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!(f3_ok && aligned)) begin
                        fault_access_d = 1'b1;
                        state_d        = FAULT;
                    end else begin
                        state_d     = BUSY;
                        cnt_d       = '0;
                        f3_d        = bus.req_funct3;
                        load_d      = bus.req_load;
                        addr_lo_d   = bus.req_addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~bus.req_load;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wstrb_d = bus.req_load ? 4'b0000 : st_strb;
                        mem_wdata_d = bus.req_load ? 32'h0 : st_wdata;
                    end
                end
            end
            BUSY: begin
                // mem_ready wins over the timeout on the last allowed cycle.
                if (bus.mem_ready) begin
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_q ? ld_data : 32'h0;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d       = 1'b0;
                    fault_timeout_d = 1'b1;
                    state_d         = FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            f3_q            <= 3'b000;
            load_q          <= 1'b0;
            addr_lo_q       <= 2'b00;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_wstrb_q     <= 4'b0000;
            mem_wdata_q     <= 32'h0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0;
            fault_access_q  <= 1'b0;
            fault_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            f3_q            <= f3_d;
            load_q          <= load_d;
            addr_lo_q       <= addr_lo_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wstrb_q     <= mem_wstrb_d;
            mem_wdata_q     <= mem_wdata_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            fault_access_q  <= fault_access_d;
            fault_timeout_q <= fault_timeout_d;
        end
    end

    // stall is combinational so the core is held in the request cycle itself.
    assign bus.stall         = ((state_q == IDLE) && bus.req_valid) || (state_q == BUSY);
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.fault_access  = fault_access_q;
    assign bus.fault_timeout = fault_timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (TIMEOUT=4). The driver pushes the
// expected response and memory transaction for every request; a monitor pops
// and compares whenever the DUT pulses a response/fault or raises mem_req.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  flags;   // {fault_timeout, fault_access, resp_valid}
        logic [31:0] rdata;
        string       tag;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          len;
        string       tag;
    } memx_t;

    resp_t resp_q[$];
    memx_t mem_q[$];

    int total = 0;
    int bad   = 0;

    int          mem_delay = 0;
    logic [31:0] mem_word  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: answer mem_delay cycles after mem_req rises.
    initial begin
        int mem_wait;
        mem_wait = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (mem_wait == mem_delay) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_word;
                end else begin
                    bus.mem_ready = 1'b0;
                end
                mem_wait++;
            end else begin
                bus.mem_ready = 1'b0;
                mem_wait = 0;
            end
        end
    end

    // Monitor: response/fault pulses and memory transactions.
    initial begin
        logic [2:0] obs;
        logic       prev_req;
        int         cur_len;
        memx_t      cur;
        resp_t      r;
        prev_req = 1'b0;
        cur_len  = 0;
        forever begin
            @(negedge clk);
            obs = {bus.fault_timeout, bus.fault_access, bus.resp_valid};
            if (obs != 3'b000) begin
                if (resp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp actual=%b required=none", obs);
                end else begin
                    r = resp_q.pop_front();
                    chk({r.tag, " flags"}, 32'(obs), 32'(r.flags));
                    if (r.flags == 3'b001)
                        chk({r.tag, " rdata"}, bus.resp_rdata, r.rdata);
                end
            end
            if (bus.mem_req === 1'b1 && !prev_req) begin
                if (mem_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_mem_req actual=1 required=0");
                    cur.len = 0;
                    cur.tag = "unexpected";
                    cur.addr = bus.mem_addr;
                    cur.wdata = bus.mem_wdata;
                end else begin
                    cur = mem_q.pop_front();
                    chk({cur.tag, " mem_we"}, 32'(bus.mem_we), 32'(cur.we));
                    chk({cur.tag, " mem_addr"}, bus.mem_addr, cur.addr);
                    chk({cur.tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(cur.strb));
                    if (cur.we)
                        chk({cur.tag, " mem_wdata"}, bus.mem_wdata, cur.wdata);
                end
                cur_len = 1;
            end else if (bus.mem_req === 1'b1) begin
                cur_len++;
                chk({cur.tag, " mem_addr_hold"}, bus.mem_addr, cur.addr);
                if (cur.we)
                    chk({cur.tag, " mem_wdata_hold"}, bus.mem_wdata, cur.wdata);
            end else if (prev_req) begin
                chk({cur.tag, " mem_req_len"}, 32'(cur_len), 32'(cur.len));
            end
            prev_req = (bus.mem_req === 1'b1);
        end
    end

    // Issue one request, queue its expectations, and count stall cycles.
    task automatic issue(input string tag, input logic ld, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] word,
                         input logic [2:0] exp_flags, input logic [31:0] exp_rdata,
                         input logic exp_mem, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input int exp_len,
                         input int exp_stall);
        resp_t r;
        memx_t m;
        int    stall_cnt;
        r.flags = exp_flags;
        r.rdata = exp_rdata;
        r.tag   = tag;
        resp_q.push_back(r);
        if (exp_mem) begin
            m.we    = ~ld;
            m.addr  = {addr[31:2], 2'b00};
            m.strb  = exp_strb;
            m.wdata = exp_wdata;
            m.len   = exp_len;
            m.tag   = tag;
            mem_q.push_back(m);
        end
        mem_delay = delay;
        mem_word  = word;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        #1;
        stall_cnt = (bus.stall === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.stall === 1'b1) stall_cnt++;
            else break;
        end
        chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        @(negedge clk);
    endtask

    initial begin
        memx_t m;
        bus.req_valid  = 1'b0;
        bus.req_load   = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst mem_req", 32'(bus.mem_req), 0);
        chk("rst mem_we", 32'(bus.mem_we), 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_wstrb", 32'(bus.mem_wstrb), 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst resp_valid", 32'(bus.resp_valid), 0);
        chk("rst resp_rdata", bus.resp_rdata, 0);
        chk("rst faults", 32'({bus.fault_access, bus.fault_timeout}), 0);
        chk("rst stall", 32'(bus.stall), 0);
        reset = 1'b0;
        @(negedge clk);

        // Stores, memory answers immediately
        issue("sw", 0, 3'b010, 32'h10, 32'h5, 0, 32'h0,
              3'b001, 32'h0, 1, 4'b1111, 32'h0000_0005, 1, 2);
        issue("sb", 0, 3'b000, 32'h13, 32'h1234_56AB, 0, 32'h0,
              3'b001, 32'h0, 1, 4'b1000, 32'hABAB_ABAB, 1, 2);
        issue("sh", 0, 3'b001, 32'h12, 32'h1234_56AB, 0, 32'h0,
              3'b001, 32'h0, 1, 4'b1100, 32'h56AB_56AB, 1, 2);

        // Loads from word 0x80FF7F00
        issue("lb12", 1, 3'b000, 32'h12, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'hFFFF_FFFF, 1, 4'b0000, 32'h0, 1, 2);
        issue("lbu12", 1, 3'b100, 32'h12, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'h0000_00FF, 1, 4'b0000, 32'h0, 1, 2);
        issue("lb11", 1, 3'b000, 32'h11, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'h0000_007F, 1, 4'b0000, 32'h0, 1, 2);
        issue("lb13", 1, 3'b000, 32'h13, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'hFFFF_FF80, 1, 4'b0000, 32'h0, 1, 2);
        issue("lh12", 1, 3'b001, 32'h12, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'hFFFF_80FF, 1, 4'b0000, 32'h0, 1, 2);
        issue("lhu12", 1, 3'b101, 32'h12, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'h0000_80FF, 1, 4'b0000, 32'h0, 1, 2);
        issue("lh10", 1, 3'b001, 32'h10, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'h0000_7F00, 1, 4'b0000, 32'h0, 1, 2);
        issue("lw10", 1, 3'b010, 32'h10, 32'h0, 0, 32'h80FF_7F00,
              3'b001, 32'h80FF_7F00, 1, 4'b0000, 32'h0, 1, 2);

        // Memory answers 3 cycles late (last cycle before TIMEOUT=4 expires)
        issue("lw_late", 1, 3'b010, 32'h24, 32'h0, 3, 32'h1234_5678,
              3'b001, 32'h1234_5678, 1, 4'b0000, 32'h0, 4, 5);
        issue("sw_late", 0, 3'b010, 32'h28, 32'hCAFE_F00D, 2, 32'h0,
              3'b001, 32'h0, 1, 4'b1111, 32'hCAFE_F00D, 3, 4);

        // Access faults: no memory request
        issue("lw_mis", 1, 3'b010, 32'h11, 32'h0, 0, 32'h0,
              3'b010, 32'h0, 0, 4'b0000, 32'h0, 0, 1);
        issue("st_f3_100", 0, 3'b100, 32'h10, 32'h0, 0, 32'h0,
              3'b010, 32'h0, 0, 4'b0000, 32'h0, 0, 1);
        issue("lh_mis", 1, 3'b001, 32'h13, 32'h0, 0, 32'h0,
              3'b010, 32'h0, 0, 4'b0000, 32'h0, 0, 1);
        issue("ld_f3_011", 1, 3'b011, 32'h10, 32'h0, 0, 32'h0,
              3'b010, 32'h0, 0, 4'b0000, 32'h0, 0, 1);

        // Timeout: memory never answers
        issue("lw_tmo", 1, 3'b010, 32'h20, 32'h0, 255, 32'h0,
              3'b100, 32'h0, 1, 4'b0000, 32'h0, 4, 5);

        // Reset during BUSY: mem_req drops, nothing is reported
        m.we = 1'b0; m.addr = 32'h40; m.strb = 4'b0000; m.wdata = 32'h0;
        m.len = 2; m.tag = "rst_busy";
        mem_q.push_back(m);
        mem_delay = 255;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_load   = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h40;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy mem_req", 32'(bus.mem_req), 0);
        chk("rst_busy stall", 32'(bus.stall), 0);
        repeat (6) @(negedge clk);

        issue("lw_after_rst", 1, 3'b010, 32'h44, 32'h0, 0, 32'hDEAD_BEEF,
              3'b001, 32'hDEAD_BEEF, 1, 4'b0000, 32'h0, 1, 2);

        repeat (5) @(negedge clk);
        chk("resp_q_left", 32'(resp_q.size()), 0);
        chk("mem_q_left", 32'(mem_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Load/store unit between the execute stage and data memory, handling the RV32I memory instructions (lb/lh/lw/lbu/lhu/sb/sh/sw).
- Takes one access request from exec and checks alignment and encoding.
- Drives a variable-latency word-addressed memory port with byte strobes, and returns extended load data for register writeback.
- Stalls the core while the access is outstanding.

Parameters:
- TIMEOUT, 255: max cycles mem_req is held without mem_ready before the access is aborted (legal range 1..255).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  exec presents a memory access this cycle
- req_load  in  1  1 = load, 0 = store
- req_funct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address (rs1 + imm)
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold the pipeline
- resp_valid  out  1  one-cycle pulse; resp_rdata valid for writeback
- resp_rdata  out  32  extended load data (0 for stores)
- fault_access  out  1  one-cycle pulse: misaligned or illegal funct3
- fault_timeout  out  1  one-cycle pulse: memory did not answer
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wstrb  out  4  byte strobes (0000 on loads)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when mem_ready=1
- mem_ready  in  1  memory completes access at this edge

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, resp_valid, resp_rdata, fault_access, fault_timeout.
  - Reset during BUSY drops mem_req at that edge; no response or fault is produced.
- States: IDLE, BUSY, RESP, FAULT.
- IDLE:
  - If req_valid=1, decode the request.
  - Legal loads: funct3 000/001/010/100/101. Legal stores: funct3 000/001/010.
  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Illegal or misaligned: go to FAULT; no mem_req is issued.
  - Legal: latch addr, funct3, load flag and wdata; compute strobes and data; go to BUSY with the counter at 0.
  - mem_ready is ignored in IDLE.
- Store lanes:
  - Byte: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 1111; wdata as given.
- BUSY:
  - mem_req=1. mem_we, mem_addr, mem_wstrb and mem_wdata are held stable.
  - If mem_ready=1: capture mem_rdata into resp_rdata (extended per latched funct3; 0 for stores), drop mem_req, go to RESP.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without mem_ready, drop mem_req and go to FAULT with fault_timeout set. mem_req is therefore high for exactly TIMEOUT cycles.
- Load extraction:
  - Byte lane = rdata >> (8*addr[1:0]); halfword lane = addr[1] ? rdata[31:16] : rdata[15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata holds until the next response.
  - Return to IDLE. req_valid is ignored in RESP.
- FAULT:
  - The relevant fault flag (access or timeout) pulses for exactly one cycle.
  - resp_valid stays 0 and there is no register write; return to IDLE.
- Stall: stall = (IDLE & req_valid) | BUSY, so it is combinational and low in RESP/FAULT, when the core advances.
- Latency: with mem_ready tied high, an access takes 3 cycles, with stall high for 2 of them. Each extra memory wait cycle adds 1.
- Only one access is outstanding at a time; there is no buffering of a second request.

Test Plan:
- sw, req_addr=0x10, wdata=5, mem_ready tied 1 -> mem_req 1 cycle, mem_addr=0x10, wstrb=1111, wdata=5, we=1; stall high 2 cycles; resp_valid pulses in cycle 2 with resp_rdata=0.
- sb, addr=0x13, wdata=0x123456AB -> wstrb=1000, mem_wdata=0xABABABAB. sh, addr=0x12 -> wstrb=1100, wdata=0x56AB56AB.
- Loads with mem_rdata=0x80FF7F00:
  - lb 0x12 -> 0xFFFFFFFF; lbu 0x12 -> 0x000000FF; lb 0x11 -> 0x0000007F.
  - lh 0x12 -> 0xFFFF80FF; lhu 0x12 -> 0x000080FF; lw 0x10 -> 0x80FF7F00.
- mem_ready asserted 3 cycles late -> mem_req and mem_addr stable for 4 cycles, stall high throughout, resp_valid exactly 1 cycle after the ready edge.
- Faults, no memory access:
  - lw 0x11 -> fault_access pulses 1 cycle, mem_req never high, resp_valid 0, stall high 1 cycle.
  - Store with funct3=100 -> fault_access.
- Timeout and reset, with TIMEOUT=4:
  - mem_ready held 0 -> mem_req high exactly 4 cycles, then fault_timeout pulses and stall drops.
  - Separate run: reset asserted during BUSY -> mem_req 0 after that edge, no resp_valid or fault, IDLE accepts the next request.
